// File: rtl/memory_top.sv
// Byte-wide single-port synchronous RAM with a post-reset clear engine.
// Optional clear engine enabled by defining MEM_CLEAR_EN.
module memory_top #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_enable,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clear_addr;
`endif

    // Array has no reset; the clear engine shares the single write port.
    always_ff @(posedge clk) begin
        if (reset && state == IDLE && wr_enable) begin
            mem[addr] <= wr_data;
        end
`ifdef MEM_CLEAR_EN
        else if (reset && state == CLEAR) begin
            mem[clear_addr] <= CLEAR_VALUE;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            rd_data <= '0;
`ifdef MEM_CLEAR_EN
            clear_addr <= '0;
`endif
        end else begin
            unique case (state)
                CLEAR: begin
`ifdef MEM_CLEAR_EN
                    clear_addr <= clear_addr + 1'b1;
                    if (clear_addr == '1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                IDLE: begin
                    // Old content wins on a same-cycle read and write.
                    if (rd_enable) begin
                        rd_data <= mem[addr];
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_top.sv
// Randomised self-checking bench for memory_top.
// Covers both builds; the clear checks apply when MEM_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_memory_top;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rd_enable = 1'b0;
    logic       wr_enable = 1'b0;
    logic [7:0] wr_data = '0;
    logic [15:0] addr = '0;
    logic       busy;
    logic [7:0] rd_data;

    int vectors = 0;
    int errs = 0;

    bit [7:0] ref_mem [int];
    bit       cleared = 1'b0;
    logic [7:0] exp_rd = '0;
    bit       exp_ok = 1'b1;

    always #5 clk = ~clk;

    memory_top dut (
        .clk       (clk),
        .reset     (reset),
        .rd_enable (rd_enable),
        .wr_enable (wr_enable),
        .wr_data   (wr_data),
        .addr      (addr),
        .busy      (busy),
        .rd_data   (rd_data)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit known(logic [15:0] a);
        return cleared || ref_mem.exists(int'(a));
    endfunction

    function automatic logic [7:0] lookup(logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'h00;
    endfunction

    // Called #1 after a rising edge; applies one cycle and checks rd_data.
    task automatic op(bit rd, bit wr, logic [15:0] a,
                      logic [7:0] d, string tag);
        rd_enable = rd;
        wr_enable = wr;
        addr      = a;
        wr_data   = d;
        @(posedge clk);
        if (rd) begin
            exp_ok = known(a);
            exp_rd = lookup(a);
        end
        if (wr) ref_mem[int'(a)] = d;
        #1;
        rd_enable = 1'b0;
        wr_enable = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        if (exp_ok) check(tag, 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (busy === 1'b1 && n < 70000) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    logic [15:0] pool [16];
    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("busy_in_reset", 32'(busy), 32'd1);
        check("rd_in_reset", 32'(rd_data), 32'd0);
        reset = 1'b1;
        #1;
        check("busy_after_release", 32'(busy), 32'd1);

`ifdef MEM_CLEAR_EN
        rd_enable = 1'b1;
        wr_enable = 1'b1;
        addr      = 16'h0010;
        wr_data   = 8'hFF;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (i % 250 == 0) begin
                check("busy_clear", 32'(busy), 32'd1);
                check("rd_clear", 32'(rd_data), 32'd0);
            end
        end
        reset = 1'b0;
        #1;
        check("busy_mid_clear_rst", 32'(busy), 32'd1);
        check("rd_mid_clear_rst", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_fall(n);
        check("clear_edges", 32'(n), 32'd65536);
        rd_enable = 1'b0;
        wr_enable = 1'b0;
        check("rd_after_clear", 32'(rd_data), 32'd0);
        cleared = 1'b1;
`else
        wait_fall(n);
        check("release_edges", 32'(n), 32'd1);
`endif
        exp_rd = 8'h00;
        exp_ok = 1'b1;

        op(1, 0, 16'h0000, 8'h00, "rd_0000");
        op(1, 0, 16'h1234, 8'h00, "rd_1234");
        op(1, 0, 16'hFFFF, 8'h00, "rd_ffff");
        op(1, 0, 16'h0010, 8'h00, "rd_0010");
        op(0, 1, 16'h0200, 8'hA5, "wr_0200");
        op(1, 0, 16'h0200, 8'h00, "rd_0200");
        op(1, 0, 16'h0201, 8'h00, "rd_0201");
        op(0, 1, 16'h0300, 8'h11, "wr_0300");
        op(1, 1, 16'h0300, 8'h22, "rdwr_0300");
        op(1, 0, 16'h0300, 8'h00, "rd_0300");
        op(0, 0, 16'h0300, 8'h00, "hold");
        op(0, 1, 16'hC000, 8'h5A, "wr_c000");
        op(1, 0, 16'hC000, 8'h00, "rd_c000");

        for (int i = 0; i < 16; i++) begin
            pool[i] = 16'($urandom);
        end
        pool[0] = 16'h0000;
        pool[1] = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            op(0, 1, pool[i], 8'($urandom), "seed");
        end
        for (int i = 0; i < 500; i++) begin
            op(1'($urandom), 1'($urandom), pool[$urandom_range(0, 15)],
               8'($urandom), "rand");
        end

        op(1, 0, pool[1], 8'h00, "pre_reset_rd");
        #2;
        reset = 1'b0;
        #1;
        check("busy_async_rst", 32'(busy), 32'd1);
        check("rd_async_rst", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("busy_restart", 32'(busy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
